// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: strobed requests are latched per port and issued one at a time; mem_init follows a latched request by one cycle.
// One transaction outstanding; a new strobe on a port that is still pending is dropped and flagged on the sticky err output.
module mem_arbiter #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_init,
   input  logic        r1_init,
   input  logic [2:0]  r0_read_op,
   input  logic [2:0]  r1_read_op,
   input  logic [1:0]  r0_write_op,
   input  logic [1:0]  r1_write_op,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r0_wdata,
   input  logic [31:0] r1_wdata,
   output logic        r0_ready,
   output logic        r1_ready,
   output logic [31:0] rdata,
   output logic        mem_init,
   output logic [2:0]  mem_read_op,
   output logic [1:0]  mem_write_op,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   typedef enum logic {IDLE, WAIT} state_t;

   typedef struct packed {
      logic [2:0]  read_op;
      logic [1:0]  write_op;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   state_t state_q, state_d;
   logic   pend0_q, pend0_d;
   logic   pend1_q, pend1_d;
   req_t   lat0_q, lat0_d;
   req_t   lat1_q, lat1_d;
   logic   grant_q, grant_d;
   logic   last_grant_q, last_grant_d;
   logic   err_q, err_d;
   logic   sel1;
   req_t   mem_req;

   always_comb begin
      state_d      = state_q;
      pend0_d      = pend0_q;
      pend1_d      = pend1_q;
      lat0_d       = lat0_q;
      lat1_d       = lat1_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      err_d        = err_q;
      mem_init     = 1'b0;
      mem_req      = '0;
      r0_ready     = 1'b0;
      r1_ready     = 1'b0;

      // Port 1 wins when alone, or on contention when round-robin says it is its turn.
      sel1 = pend1_q & (~pend0_q | ((FIXED_PRIO == 0) & ~last_grant_q));

      if (r0_init && !pend0_q) begin
         pend0_d = 1'b1;
         lat0_d  = '{read_op: r0_read_op, write_op: r0_write_op, addr: r0_addr, wdata: r0_wdata};
      end
      if (r1_init && !pend1_q) begin
         pend1_d = 1'b1;
         lat1_d  = '{read_op: r1_read_op, write_op: r1_write_op, addr: r1_addr, wdata: r1_wdata};
      end
      err_d = err_q | (r0_init & pend0_q) | (r1_init & pend1_q);

      case (state_q)
         IDLE: begin
            if (pend0_q || pend1_q) begin
               mem_init = 1'b1;
               mem_req  = sel1 ? lat1_q : lat0_q;
               grant_d  = sel1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            mem_req = grant_q ? lat1_q : lat0_q;
            if (mem_ready) begin
               r0_ready     = ~grant_q;
               r1_ready     = grant_q;
               last_grant_d = grant_q;
               state_d      = IDLE;
               // Pending was set on entry to WAIT, so the capture path above cannot fire here.
               if (grant_q) pend1_d = 1'b0;
               else         pend0_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pend0_q      <= 1'b0;
         pend1_q      <= 1'b0;
         lat0_q       <= '0;
         lat1_q       <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend0_q      <= pend0_d;
         pend1_q      <= pend1_d;
         lat0_q       <= lat0_d;
         lat1_q       <= lat1_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
      end
   end

   assign mem_read_op  = mem_req.read_op;
   assign mem_write_op = mem_req.write_op;
   assign mem_addr     = mem_req.addr;
   assign mem_wdata    = mem_req.wdata;
   assign rdata        = mem_rdata;
   assign err          = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one fixed-priority instance share all stimulus.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        r0_init, r1_init;
   logic [2:0]  r0_read_op, r1_read_op;
   logic [1:0]  r0_write_op, r1_write_op;
   logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   logic        rr_r0_ready, rr_r1_ready, rr_mem_init, rr_err;
   logic [31:0] rr_rdata, rr_mem_addr, rr_mem_wdata;
   logic [2:0]  rr_mem_read_op;
   logic [1:0]  rr_mem_write_op;

   logic        fp_r0_ready, fp_r1_ready, fp_mem_init, fp_err;
   logic [31:0] fp_rdata, fp_mem_addr, fp_mem_wdata;
   logic [2:0]  fp_mem_read_op;
   logic [1:0]  fp_mem_write_op;

   int n_chk  = 0;
   int n_fail = 0;
   int rdy_cnt;

   mem_arbiter #(.FIXED_PRIO(0)) u_rr (
      .clk(clk), .reset(reset),
      .r0_init(r0_init), .r1_init(r1_init),
      .r0_read_op(r0_read_op), .r1_read_op(r1_read_op),
      .r0_write_op(r0_write_op), .r1_write_op(r1_write_op),
      .r0_addr(r0_addr), .r1_addr(r1_addr),
      .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
      .r0_ready(rr_r0_ready), .r1_ready(rr_r1_ready),
      .rdata(rr_rdata), .mem_init(rr_mem_init),
      .mem_read_op(rr_mem_read_op), .mem_write_op(rr_mem_write_op),
      .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .err(rr_err)
   );

   mem_arbiter #(.FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset(reset),
      .r0_init(r0_init), .r1_init(r1_init),
      .r0_read_op(r0_read_op), .r1_read_op(r1_read_op),
      .r0_write_op(r0_write_op), .r1_write_op(r1_write_op),
      .r0_addr(r0_addr), .r1_addr(r1_addr),
      .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
      .r0_ready(fp_r0_ready), .r1_ready(fp_r1_ready),
      .rdata(fp_rdata), .mem_init(fp_mem_init),
      .mem_read_op(fp_mem_read_op), .mem_write_op(fp_mem_write_op),
      .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .err(fp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start of a new cycle: strobes default low, inputs change mid-cycle.
   task automatic nc();
      @(negedge clk);
      reset     = 1'b0;
      r0_init   = 1'b0;
      r1_init   = 1'b0;
      mem_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; r0_init = 1'b0; r1_init = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      r0_read_op = '0; r1_read_op = '0; r0_write_op = '0; r1_write_op = '0;
      r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;

      // Reset state and strobe discarded in the reset cycle
      nc(); reset = 1'b1; #1;
      chk("rst_mem_init", rr_mem_init, 0);
      chk("rst_mem_addr", rr_mem_addr, 0);
      chk("rst_err", rr_err, 0);
      nc(); reset = 1'b1; mem_ready = 1'b1; r0_init = 1'b1; r0_addr = 32'hAAA; #1;
      chk("rst_r0_ready", rr_r0_ready, 0);
      nc(); #1;
      chk("rst_init_dropped", rr_mem_init, 0);

      // Single read: strobe at cycle 5, memory ready at cycle 8
      nc(); nc();
      nc(); r0_init = 1'b1; r0_read_op = 3'b010; r0_addr = 32'h100; #1;
      chk("rd_c5_init", rr_mem_init, 0);
      nc(); r0_addr = 32'hFFF; r0_read_op = 3'b111; #1;
      chk("rd_c6_init", rr_mem_init, 1);
      chk("rd_c6_addr", rr_mem_addr, 32'h100);
      chk("rd_c6_rop", rr_mem_read_op, 3'b010);
      chk("rd_c6_rdy", rr_r0_ready, 0);
      nc(); #1;
      chk("rd_c7_init", rr_mem_init, 0);
      chk("rd_c7_addr", rr_mem_addr, 32'h100);
      chk("rd_c7_rdy", rr_r0_ready, 0);
      nc(); mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
      chk("rd_c8_r0rdy", rr_r0_ready, 1);
      chk("rd_c8_r1rdy", rr_r1_ready, 0);
      chk("rd_c8_rdata", rr_rdata, 32'hDEADBEEF);
      chk("rd_c8_addr", rr_mem_addr, 32'h100);
      nc(); mem_ready = 1'b1; #1;
      chk("idle_ready_ignored", rr_r0_ready, 0);
      chk("idle_init", rr_mem_init, 0);
      chk("idle_addr", rr_mem_addr, 0);

      // Round-robin with four simultaneous pairs
      nc(); reset = 1'b1;
      nc(); reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nc(); r0_init = 1'b1; r1_init = 1'b1;
         r0_addr = 32'h1000 + 32'(i); r1_addr = 32'h2000 + 32'(i); #1;
         nc(); #1;
         chk("rr_first_init", rr_mem_init, 1);
         chk("rr_first_addr", rr_mem_addr, 32'h1000 + 32'(i));
         nc(); mem_ready = 1'b1; #1;
         chk("rr_first_ready", {rr_r1_ready, rr_r0_ready}, 2'b01);
         nc(); #1;
         chk("rr_second_init", rr_mem_init, 1);
         chk("rr_second_addr", rr_mem_addr, 32'h2000 + 32'(i));
         nc(); mem_ready = 1'b1; #1;
         chk("rr_second_ready", {rr_r1_ready, rr_r0_ready}, 2'b10);
      end
      chk("rr_no_err", rr_err, 0);

      // Fixed priority: port 0 served first after being the last grant
      nc(); reset = 1'b1;
      nc(); reset = 1'b1;
      nc(); r0_init = 1'b1; r0_addr = 32'h3000; r0_read_op = 3'b001; #1;
      nc(); #1;
      chk("fp_solo_addr", fp_mem_addr, 32'h3000);
      nc(); mem_ready = 1'b1; #1;
      chk("fp_solo_ready", fp_r0_ready, 1);
      nc(); r0_init = 1'b1; r1_init = 1'b1; r0_addr = 32'h3100; r1_addr = 32'h4100; #1;
      nc(); #1;
      chk("fp_contend_addr", fp_mem_addr, 32'h3100);
      chk("rr_contend_addr", rr_mem_addr, 32'h4100);
      nc(); mem_ready = 1'b1; #1;
      chk("fp_contend_ready", {fp_r1_ready, fp_r0_ready}, 2'b01);
      nc(); r0_init = 1'b1; r0_addr = 32'h3200; #1;
      chk("fp_p1_init", fp_mem_init, 1);
      chk("fp_p1_addr", fp_mem_addr, 32'h4100);
      nc(); mem_ready = 1'b1; #1;
      chk("fp_p1_ready", {fp_r1_ready, fp_r0_ready}, 2'b10);
      nc(); #1;
      chk("fp_p0_again", fp_mem_addr, 32'h3200);
      nc(); mem_ready = 1'b1; #1;
      chk("fp_p0_again_rdy", fp_r0_ready, 1);
      chk("fp_no_err", fp_err, 0);

      // Overrun: second r1 strobe while pending, memory stalled
      nc(); reset = 1'b1;
      nc(); reset = 1'b1;
      nc(); r1_init = 1'b1; r1_addr = 32'h5000; r1_wdata = 32'hCAFE0001;
      r1_write_op = 2'b01; r1_read_op = 3'b000; #1;
      rdy_cnt = 0;
      nc(); #1;
      chk("ovr_init", rr_mem_init, 1);
      chk("ovr_addr", rr_mem_addr, 32'h5000);
      rdy_cnt += int'(rr_r1_ready);
      nc(); r1_init = 1'b1; r1_addr = 32'h6000; r1_wdata = 32'h66666666; #1;
      chk("ovr_err_before", rr_err, 0);
      rdy_cnt += int'(rr_r1_ready);
      for (int i = 0; i < 8; i++) begin
         nc(); #1;
         rdy_cnt += int'(rr_r1_ready);
      end
      chk("ovr_err", rr_err, 1);
      chk("ovr_addr_kept", rr_mem_addr, 32'h5000);
      chk("ovr_wdata_kept", rr_mem_wdata, 32'hCAFE0001);
      nc(); mem_ready = 1'b1; #1;
      chk("ovr_ready", rr_r1_ready, 1);
      chk("ovr_ready_addr", rr_mem_addr, 32'h5000);
      rdy_cnt += int'(rr_r1_ready);
      nc(); #1;
      chk("ovr_no_reissue", rr_mem_init, 0);
      chk("ovr_err_sticky", rr_err, 1);
      rdy_cnt += int'(rr_r1_ready);
      nc(); #1;
      rdy_cnt += int'(rr_r1_ready);
      chk("ovr_ready_count", 32'(rdy_cnt), 1);

      // Reset in WAIT abandons the transaction, late mem_ready ignored
      nc(); r0_init = 1'b1; r0_addr = 32'h7000; #1;
      chk("rw_err_pre", rr_err, 1);
      nc(); #1;
      chk("rw_init", rr_mem_init, 1);
      nc(); reset = 1'b1; #1;
      chk("rw_wait_addr", rr_mem_addr, 32'h7000);
      nc(); #1;
      chk("rw_err_clr", rr_err, 0);
      chk("rw_idle_init", rr_mem_init, 0);
      chk("rw_idle_addr", rr_mem_addr, 0);
      nc(); mem_ready = 1'b1; #1;
      chk("rw_late_ready", {rr_r1_ready, rr_r0_ready}, 2'b00);
      chk("rw_late_init", rr_mem_init, 0);
      nc(); #1;
      chk("rw_quiet", rr_mem_init, 0);
      nc(); r1_init = 1'b1; r1_addr = 32'h7100; r1_write_op = 2'b00; #1;
      chk("rw_new_pre", rr_mem_init, 0);
      nc(); #1;
      chk("rw_new_init", rr_mem_init, 1);
      chk("rw_new_addr", rr_mem_addr, 32'h7100);
      nc(); mem_ready = 1'b1; #1;
      chk("rw_new_ready", rr_r1_ready, 1);

      // Write queued behind a read, issued back-to-back
      nc(); r0_init = 1'b1; r0_addr = 32'h8000; r0_read_op = 3'b011;
      r0_write_op = 2'b00; r0_wdata = 32'h0; #1;
      nc(); #1;
      chk("b2b_rd_init", rr_mem_init, 1);
      chk("b2b_rd_rop", rr_mem_read_op, 3'b011);
      nc(); r1_init = 1'b1; r1_addr = 32'h9000; r1_write_op = 2'b11;
      r1_wdata = 32'h12345678; r1_read_op = 3'b000; #1;
      chk("b2b_rd_addr", rr_mem_addr, 32'h8000);
      chk("b2b_rd_wop", rr_mem_write_op, 2'b00);
      nc(); r1_addr = 32'h0; r1_wdata = 32'h0; r1_write_op = 2'b00; #1;
      chk("b2b_wait_init", rr_mem_init, 0);
      nc(); mem_ready = 1'b1; #1;
      chk("b2b_r0_ready", rr_r0_ready, 1);
      nc(); #1;
      chk("b2b_wr_init", rr_mem_init, 1);
      chk("b2b_wr_addr", rr_mem_addr, 32'h9000);
      chk("b2b_wr_wop", rr_mem_write_op, 2'b11);
      chk("b2b_wr_wdata", rr_mem_wdata, 32'h12345678);
      chk("b2b_wr_rop", rr_mem_read_op, 3'b000);
      for (int i = 0; i < 2; i++) begin
         nc(); #1;
         chk("b2b_hold_init", rr_mem_init, 0);
         chk("b2b_hold_wop", rr_mem_write_op, 2'b11);
         chk("b2b_hold_wdata", rr_mem_wdata, 32'h12345678);
      end
      nc(); mem_ready = 1'b1; #1;
      chk("b2b_r1_ready", rr_r1_ready, 1);
      chk("b2b_rdy_wop", rr_mem_write_op, 2'b11);
      nc(); #1;
      chk("b2b_idle_wop", rr_mem_write_op, 2'b00);
      chk("b2b_idle_wdata", rr_mem_wdata, 32'h0);
      chk("end_rr_err", rr_err, 0);
      chk("end_fp_err", fp_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0, where 0 selects round-robin arbitration and 1 gives port 0 absolute priority.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports r0_init and r1_init, input, 1 bit each: a one-cycle request strobe per requester.
REQ-005 The block SHALL have ports r0_read_op and r1_read_op, input, 3 bits each: read op code, passed through unchanged.
REQ-006 The block SHALL have ports r0_write_op and r1_write_op, input, 2 bits each: write op code, passed through unchanged.
REQ-007 The block SHALL have ports r0_addr, r1_addr, r0_wdata and r1_wdata, input, 32 bits each: request address and write data.
REQ-008 The block SHALL have ports r0_ready and r1_ready, output, 1 bit each: completion pulse per requester.
REQ-009 The block SHALL have port rdata, output, 32 bits: read data shared by both requesters.
REQ-010 The block SHALL have port mem_init, output, 1 bit: one-cycle strobe to memory.
REQ-011 The block SHALL have ports mem_read_op (output, 3 bits), mem_write_op (output, 2 bits), mem_addr (output, 32 bits) and mem_wdata (output, 32 bits): the granted request fields.
REQ-012 The block SHALL have ports mem_ready (input, 1 bit) and mem_rdata (input, 32 bits): memory completion and read data.
REQ-013 The block SHALL have port err, output, 1 bit: sticky overrun flag.

Function
REQ-014 Each port SHALL own a pending bit plus latched read_op, write_op, addr and wdata; these are captured at the edge where rN_init=1 and pending=0.
REQ-015 The FSM SHALL have two states, IDLE and WAIT.
REQ-016 In IDLE with any pending bit set, the block SHALL select a port, assert mem_init for exactly that cycle, record the grant and go to WAIT.
REQ-017 Selection rule: with one port pending, that port wins; with both pending, FIXED_PRIO=1 picks port 0, and FIXED_PRIO=0 picks the port not equal to last_grant.
REQ-018 In WAIT the block SHALL hold mem_read_op, mem_write_op, mem_addr and mem_wdata stable from the granted latch, keep mem_init=0, and stay in WAIT until mem_ready=1.
REQ-019 rN_ready SHALL be combinational: mem_ready AND state==WAIT AND grant==N; rdata SHALL equal mem_rdata at all times.
REQ-020 At the edge where mem_ready=1 in WAIT, the block SHALL clear the granted pending bit, set last_grant to the granted port and go to IDLE.
REQ-021 Latency: rN_init in cycle t with memory idle and no contention SHALL give mem_init in cycle t+1; ready is returned in the same cycle memory asserts mem_ready.
REQ-022 Back-to-back: after completion the next pending request SHALL issue mem_init in the cycle directly after the completion cycle; no extra bubble.
REQ-023 mem_ready seen in IDLE SHALL be ignored: no ready pulse and no state change.
REQ-024 rN_init while port N is already pending, including in the cycle its ready is pulsed, SHALL be dropped and SHALL set err; err is cleared only by reset.
REQ-025 Simultaneous r0_init and r1_init in IDLE with nothing pending SHALL latch both; arbitration SHALL resolve in the following cycle per REQ-017.
REQ-026 In IDLE, mem_read_op, mem_write_op, mem_addr and mem_wdata SHALL be 0, except in the mem_init cycle, where they carry the selected latch.

Reset
REQ-027 Reset SHALL force the following values: state=IDLE, both pending bits=0, all latches=0, last_grant=1 (port 0 wins first contention), err=0, mem_init=0, and mem_* request outputs=0.
REQ-028 Reset asserted in WAIT SHALL abandon the transaction; no rN_ready pulse SHALL follow, and a late mem_ready after reset is ignored per REQ-023.
REQ-029 rN_init sampled in the same cycle as reset SHALL be discarded.

Verification
REQ-030 The bench SHALL drive r0 read, addr=0x100, read_op=3'b010 at cycle 5, with mem_ready at cycle 8 and mem_rdata=0xDEADBEEF. Required: mem_init=1 only at cycle 6, mem_addr=0x100 in cycles 6-8, r0_ready=1 only at cycle 8, rdata=0xDEADBEEF.
REQ-031 The bench SHALL drive r0_init and r1_init in the same cycle with FIXED_PRIO=0, then 3 more simultaneous pairs. Required: grants alternate 0,1,0,1,... and no port starves.
REQ-032 The bench SHALL run the REQ-031 stimulus with FIXED_PRIO=1 and r0 re-requesting on each r0_ready. Required: port 0 always wins while pending; port 1 is served only when port 0 is not pending.
REQ-033 The bench SHALL pulse r1_init twice, 2 cycles apart, with memory stalled for 10 cycles. Required: the second strobe is dropped, err=1, exactly one r1_ready, and the first addr/wdata are unchanged.
REQ-034 The bench SHALL assert reset in WAIT, then assert mem_ready 2 cycles later. Required: no rN_ready, err=0, state IDLE, and mem_init=0 until a new request.
REQ-035 The bench SHALL drive a write with r1_write_op=2'b11 and wdata=0x12345678 back-to-back behind a pending r0 read. Required: the second mem_init occurs in the cycle after r0_ready, and mem_write_op=2'b11 and mem_wdata=0x12345678 are held through WAIT.
